// File: rtl/pipeline_id_hazard.sv
// ----------------------------------------------------------------------------
// pipeline_id_hazard
//
// Decode stage for a 5-stage RISC-V pipeline. It contains:
//   * the integer register file, with write-through bypass from WB
//   * a load-use scoreboard that stalls IF and inserts EX bubbles
//   * the ID/EX pipeline register, with flush (squash) support
//   * a saturating counter of stall cycles
// Control decode and immediate generation happen upstream. Their results
// arrive here already decoded.
//
// Parameters
//   XLEN       datapath width
//   AW         register address width (2**AW registers, x0 reads as zero)
//   CTRL_W     width of the opaque decoded-control bundle forwarded to EX
//   LOAD_STALL cycles a load result stays unavailable after leaving ID (1..4)
//   CNT_W      width of the stall performance counter
//
// Ports
//   clk_ID, rst_n_ID            clock (rising edge), async active-low reset
//   valid_ID                    IF/ID holds a real instruction
//   rs1/rs2_addr_ID, _used_ID   source registers and whether they are read
//   rd_addr_ID, regwrite_ID     destination register and its write enable
//   memread_ID                  instruction is a load
//   ctrl_ID, imm_ID, pc_ID      decoded control, immediate, PC
//   wb_we, wb_addr, wb_data     register-file write port from WB
//   flush_EX                    taken branch/jump in EX; squash ID
//   stall_IF                    hold PC and IF/ID this cycle
//   ex_*                        ID/EX pipeline register outputs
//   stall_cycles                saturating count of stall cycles
// ----------------------------------------------------------------------------
module pipeline_id_hazard #(
   parameter int XLEN       = 32,
   parameter int AW         = 5,
   parameter int CTRL_W     = 16,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk_ID,
   input  logic              rst_n_ID,
   input  logic              valid_ID,
   input  logic [AW-1:0]     rs1_addr_ID,
   input  logic [AW-1:0]     rs2_addr_ID,
   input  logic              rs1_used_ID,
   input  logic              rs2_used_ID,
   input  logic [AW-1:0]     rd_addr_ID,
   input  logic              regwrite_ID,
   input  logic              memread_ID,
   input  logic [CTRL_W-1:0] ctrl_ID,
   input  logic [XLEN-1:0]   imm_ID,
   input  logic [XLEN-1:0]   pc_ID,
   input  logic              wb_we,
   input  logic [AW-1:0]     wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush_EX,
   output logic              stall_IF,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_pc,
   output logic [AW-1:0]     ex_rs1_addr,
   output logic [AW-1:0]     ex_rs2_addr,
   output logic [AW-1:0]     ex_rd,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int NREG = 2 ** AW;

   // ------------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------------
   // The whole file is cleared by reset, so it is built from flops rather
   // than RAM. Entry 0 is never written and therefore stays zero.
   logic [XLEN-1:0] regs_reg [NREG];

   always_ff @(posedge clk_ID or negedge rst_n_ID) begin
      if (!rst_n_ID) begin
         for (int i = 0; i < NREG; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (wb_we && (wb_addr != '0)) begin
         regs_reg[wb_addr] <= wb_data;
      end
   end

   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;

   // The WB write lands on the same edge that ID/EX captures. Bypassing it
   // here avoids a stall for a same-cycle producer and consumer. x0 wins
   // over everything.
   always_comb begin
      rs1_data = regs_reg[rs1_addr_ID];
      if (wb_we && (wb_addr == rs1_addr_ID)) begin
         rs1_data = wb_data;
      end
      if (rs1_addr_ID == '0) begin
         rs1_data = '0;
      end
   end

   always_comb begin
      rs2_data = regs_reg[rs2_addr_ID];
      if (wb_we && (wb_addr == rs2_addr_ID)) begin
         rs2_data = wb_data;
      end
      if (rs2_addr_ID == '0) begin
         rs2_data = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Load-use scoreboard
   // ------------------------------------------------------------------------
   // Entry k is a load that left ID k+1 edges ago and whose result is not
   // yet forwardable. The entries form a shift register. Entry 0 records
   // only loads that actually issue, so a stalled or flushed instruction
   // never registers itself. x0 is never recorded, so x0 can never match.
   logic [LOAD_STALL-1:0] sb_pv_reg;
   logic [AW-1:0]         sb_prd_reg [LOAD_STALL];
   logic [LOAD_STALL-1:0] match;
   logic                  hz;
   logic                  issue;
   logic                  load_issue;

   generate
      for (genvar gi = 0; gi < LOAD_STALL; gi++) begin : g_match
         assign match[gi] = sb_pv_reg[gi] &&
                            ((rs1_used_ID && (sb_prd_reg[gi] == rs1_addr_ID)) ||
                             (rs2_used_ID && (sb_prd_reg[gi] == rs2_addr_ID)));
      end
   endgenerate

   // A flush overrides a hazard. The squashed instruction never needs its
   // operands, so it must not stall the front end.
   assign hz         = valid_ID && !flush_EX && (|match);
   assign stall_IF   = hz;
   assign issue      = valid_ID && !hz && !flush_EX;
   assign load_issue = issue && memread_ID && regwrite_ID && (rd_addr_ID != '0);

   // Older entries keep shifting during stalls and flushes. The loads they
   // track are already past ID and remain live.
   always_ff @(posedge clk_ID or negedge rst_n_ID) begin
      if (!rst_n_ID) begin
         sb_pv_reg <= '0;
         for (int k = 0; k < LOAD_STALL; k++) begin
            sb_prd_reg[k] <= '0;
         end
      end else begin
         sb_pv_reg[0]  <= load_issue;
         sb_prd_reg[0] <= load_issue ? rd_addr_ID : '0;
         for (int k = 1; k < LOAD_STALL; k++) begin
            sb_pv_reg[k]  <= sb_pv_reg[k-1];
            sb_prd_reg[k] <= sb_prd_reg[k-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // ID/EX pipeline register
   // ------------------------------------------------------------------------
   // A bubble clears only the fields that can cause side effects in later
   // stages. The data fields keep their last values because EX ignores
   // them when ex_valid is low.
   always_ff @(posedge clk_ID or negedge rst_n_ID) begin
      if (!rst_n_ID) begin
         ex_valid    <= 1'b0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_pc       <= '0;
         ex_rs1_addr <= '0;
         ex_rs2_addr <= '0;
         ex_rd       <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_ctrl     <= '0;
      end else if (issue) begin
         ex_valid    <= 1'b1;
         ex_rs1_data <= rs1_data;
         ex_rs2_data <= rs2_data;
         ex_imm      <= imm_ID;
         ex_pc       <= pc_ID;
         ex_rs1_addr <= rs1_addr_ID;
         ex_rs2_addr <= rs2_addr_ID;
         ex_rd       <= rd_addr_ID;
         ex_regwrite <= regwrite_ID;
         ex_memread  <= memread_ID;
         ex_ctrl     <= ctrl_ID;
      end else begin
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_ctrl     <= '0;
      end
   end

   // ------------------------------------------------------------------------
   // Stall performance counter (saturating)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_ID or negedge rst_n_ID) begin
      if (!rst_n_ID) begin
         stall_cycles <= '0;
      end else if (stall_IF && (stall_cycles != {CNT_W{1'b1}})) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_id_hazard.sv
// ----------------------------------------------------------------------------
// Testbench for pipeline_id_hazard.
// Two instances share the same ID-stage stimulus:
//   u_ls1: LOAD_STALL=1, CNT_W=16
//   u_ls2: LOAD_STALL=2, CNT_W=3 (a narrow counter so saturation is reachable)
// Inputs change 1 time unit after the rising edge. Outputs are sampled
// before the next rising edge.
// ----------------------------------------------------------------------------
module tb_pipeline_id_hazard;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        rs1_used, rs2_used, regwrite, memread;
   logic [15:0] ctrl;
   logic [31:0] imm, pc;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;

   logic        stall_a, ex_valid_a, ex_regwrite_a, ex_memread_a;
   logic [31:0] ex_rs1_data_a, ex_rs2_data_a, ex_imm_a, ex_pc_a;
   logic [4:0]  ex_rs1_addr_a, ex_rs2_addr_a, ex_rd_a;
   logic [15:0] ex_ctrl_a;
   logic [15:0] stall_cycles_a;

   logic        stall_b, ex_valid_b, ex_regwrite_b, ex_memread_b;
   logic [31:0] ex_rs1_data_b, ex_rs2_data_b, ex_imm_b, ex_pc_b;
   logic [4:0]  ex_rs1_addr_b, ex_rs2_addr_b, ex_rd_b;
   logic [15:0] ex_ctrl_b;
   logic [2:0]  stall_cycles_b;

   int tests  = 0;
   int failed = 0;

   pipeline_id_hazard #(.XLEN(32), .AW(5), .CTRL_W(16), .LOAD_STALL(1), .CNT_W(16)) u_ls1 (
      .clk_ID(clk), .rst_n_ID(rst_n), .valid_ID(valid),
      .rs1_addr_ID(rs1_addr), .rs2_addr_ID(rs2_addr),
      .rs1_used_ID(rs1_used), .rs2_used_ID(rs2_used),
      .rd_addr_ID(rd_addr), .regwrite_ID(regwrite), .memread_ID(memread),
      .ctrl_ID(ctrl), .imm_ID(imm), .pc_ID(pc),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush_EX(flush),
      .stall_IF(stall_a), .ex_valid(ex_valid_a),
      .ex_rs1_data(ex_rs1_data_a), .ex_rs2_data(ex_rs2_data_a),
      .ex_imm(ex_imm_a), .ex_pc(ex_pc_a),
      .ex_rs1_addr(ex_rs1_addr_a), .ex_rs2_addr(ex_rs2_addr_a), .ex_rd(ex_rd_a),
      .ex_regwrite(ex_regwrite_a), .ex_memread(ex_memread_a),
      .ex_ctrl(ex_ctrl_a), .stall_cycles(stall_cycles_a)
   );

   pipeline_id_hazard #(.XLEN(32), .AW(5), .CTRL_W(16), .LOAD_STALL(2), .CNT_W(3)) u_ls2 (
      .clk_ID(clk), .rst_n_ID(rst_n), .valid_ID(valid),
      .rs1_addr_ID(rs1_addr), .rs2_addr_ID(rs2_addr),
      .rs1_used_ID(rs1_used), .rs2_used_ID(rs2_used),
      .rd_addr_ID(rd_addr), .regwrite_ID(regwrite), .memread_ID(memread),
      .ctrl_ID(ctrl), .imm_ID(imm), .pc_ID(pc),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush_EX(flush),
      .stall_IF(stall_b), .ex_valid(ex_valid_b),
      .ex_rs1_data(ex_rs1_data_b), .ex_rs2_data(ex_rs2_data_b),
      .ex_imm(ex_imm_b), .ex_pc(ex_pc_b),
      .ex_rs1_addr(ex_rs1_addr_b), .ex_rs2_addr(ex_rs2_addr_b), .ex_rd(ex_rd_b),
      .ex_regwrite(ex_regwrite_b), .ex_memread(ex_memread_b),
      .ex_ctrl(ex_ctrl_b), .stall_cycles(stall_cycles_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
      rd_addr = 0; regwrite = 0; memread = 0; ctrl = 0; imm = 0; pc = 0;
      wb_we = 0; wb_addr = 0; wb_data = 0; flush = 0;
   endtask

   task automatic instr(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic rw,
                        input logic mr);
      valid = 1; rs1_addr = r1; rs2_addr = r2; rs1_used = u1; rs2_used = u2;
      rd_addr = rd; regwrite = rw; memread = mr;
   endtask

   task automatic test_reset;
      #3;
      tests++; if (stall_a !== 1'b0) begin failed++; $display("FAIL reset_stall got=%b exp=0", stall_a); end
      tests++; if (ex_valid_a !== 1'b0) begin failed++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid_a); end
      tests++; if (ex_ctrl_a !== 16'h0) begin failed++; $display("FAIL reset_ex_ctrl got=%h exp=0", ex_ctrl_a); end
      tests++; if (ex_rs1_data_a !== 32'h0) begin failed++; $display("FAIL reset_ex_rs1 got=%h exp=0", ex_rs1_data_a); end
      tests++; if (stall_cycles_a !== 16'h0) begin failed++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles_a); end
      $display("[TB] reset: stall=%b ex_valid=%b cnt=%0d", stall_a, ex_valid_a, stall_cycles_a);
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   task automatic test_regfile;
      idle();
      wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
      tick();
      wb_we = 0;
      instr(5, 0, 1, 0, 0, 0, 0);
      ctrl = 16'hA5C3; imm = 32'h0000_0010; pc = 32'h0000_0100;
      tick();
      tests++; if (ex_valid_a !== 1'b1) begin failed++; $display("FAIL rf_ex_valid got=%b exp=1", ex_valid_a); end
      tests++; if (ex_rs1_data_a !== 32'hDEADBEEF) begin failed++; $display("FAIL rf_x5 got=%h exp=deadbeef", ex_rs1_data_a); end
      tests++; if (ex_rs1_addr_a !== 5'd5) begin failed++; $display("FAIL rf_rs1_addr got=%0d exp=5", ex_rs1_addr_a); end
      tests++; if (ex_ctrl_a !== 16'hA5C3) begin failed++; $display("FAIL rf_ctrl got=%h exp=a5c3", ex_ctrl_a); end
      tests++; if (ex_imm_a !== 32'h10 || ex_pc_a !== 32'h100) begin failed++; $display("FAIL rf_imm_pc got=%h/%h exp=10/100", ex_imm_a, ex_pc_a); end
      $display("[TB] read x5: ex_rs1_data=%h", ex_rs1_data_a);
      idle();
      wb_we = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
      tick();
      // read x0 on both ports while WB also targets x0
      instr(0, 0, 1, 1, 0, 0, 0);
      wb_we = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
      tick();
      tests++; if (ex_rs1_data_a !== 32'h0 || ex_rs2_data_a !== 32'h0) begin failed++; $display("FAIL rf_x0 got=%h/%h exp=0/0", ex_rs1_data_a, ex_rs2_data_a); end
      $display("[TB] read x0: ex_rs1_data=%h ex_rs2_data=%h", ex_rs1_data_a, ex_rs2_data_a);
      idle();
   endtask

   task automatic test_bypass;
      idle();
      instr(0, 7, 0, 1, 0, 0, 0);
      wb_we = 1; wb_addr = 7; wb_data = 32'h1234;
      #1;
      tests++; if (stall_a !== 1'b0) begin failed++; $display("FAIL byp_stall got=%b exp=0", stall_a); end
      tick();
      tests++; if (ex_rs2_data_a !== 32'h1234) begin failed++; $display("FAIL byp_rs2 got=%h exp=1234", ex_rs2_data_a); end
      wb_we = 0;
      instr(7, 0, 1, 0, 0, 0, 0);
      tick();
      tests++; if (ex_rs1_data_a !== 32'h1234) begin failed++; $display("FAIL byp_stored got=%h exp=1234", ex_rs1_data_a); end
      $display("[TB] bypass x7: ex_rs2_data(bypass)=%h later ex_rs1_data=%h", ex_rs2_data_a, ex_rs1_data_a);
      idle();
   endtask

   task automatic test_load_use_ls1;
      logic [15:0] sc;
      idle();
      tick(); tick(); tick();
      sc = stall_cycles_a;
      instr(2, 0, 1, 0, 3, 1, 1);
      #1;
      tests++; if (stall_a !== 1'b0) begin failed++; $display("FAIL ls1_load_stall got=%b exp=0", stall_a); end
      tick();
      tests++; if (ex_memread_a !== 1'b1 || ex_rd_a !== 5'd3) begin failed++; $display("FAIL ls1_load_ex got=%b/%0d exp=1/3", ex_memread_a, ex_rd_a); end
      instr(3, 3, 1, 1, 4, 1, 0);
      #1;
      tests++; if (stall_a !== 1'b1) begin failed++; $display("FAIL ls1_stall got=%b exp=1", stall_a); end
      tick();
      tests++; if (ex_valid_a !== 1'b0 || ex_regwrite_a !== 1'b0) begin failed++; $display("FAIL ls1_bubble got=%b/%b exp=0/0", ex_valid_a, ex_regwrite_a); end
      tests++; if (stall_a !== 1'b0) begin failed++; $display("FAIL ls1_stall_end got=%b exp=0", stall_a); end
      tick();
      tests++; if (ex_valid_a !== 1'b1 || ex_rd_a !== 5'd4) begin failed++; $display("FAIL ls1_add_issue got=%b/%0d exp=1/4", ex_valid_a, ex_rd_a); end
      tests++; if (stall_cycles_a !== sc + 16'd1) begin failed++; $display("FAIL ls1_cnt got=%0d exp=%0d", stall_cycles_a, sc + 16'd1); end
      $display("[TB] LS1 load x3; add x4,x3,x3: stall_cycles=%0d", stall_cycles_a);
      idle();
   endtask

   task automatic test_load_use_ls2;
      logic [2:0] sc;
      int n;
      idle();
      tick(); tick(); tick();
      sc = stall_cycles_b;
      instr(2, 0, 1, 0, 3, 1, 1);
      tick();
      instr(1, 2, 1, 1, 6, 1, 0);
      #1;
      tests++; if (stall_b !== 1'b0) begin failed++; $display("FAIL ls2_unrel_stall got=%b exp=0", stall_b); end
      tick();
      instr(3, 0, 1, 0, 8, 1, 0);
      #1;
      tests++; if (stall_b !== 1'b1) begin failed++; $display("FAIL ls2_gap_stall got=%b exp=1", stall_b); end
      tick();
      tests++; if (stall_b !== 1'b0 || ex_valid_b !== 1'b0) begin failed++; $display("FAIL ls2_gap_end got=%b/%b exp=0/0", stall_b, ex_valid_b); end
      tick();
      tests++; if (ex_valid_b !== 1'b1 || ex_rd_b !== 5'd8) begin failed++; $display("FAIL ls2_gap_issue got=%b/%0d exp=1/8", ex_valid_b, ex_rd_b); end
      tests++; if (stall_cycles_b !== sc + 3'd1) begin failed++; $display("FAIL ls2_gap_cnt got=%0d exp=%0d", stall_cycles_b, sc + 3'd1); end
      $display("[TB] LS2 load; unrelated; use: stall_cycles=%0d", stall_cycles_b);

      idle();
      tick(); tick(); tick();
      sc = stall_cycles_b;
      instr(2, 0, 1, 0, 3, 1, 1);
      tick();
      instr(0, 3, 0, 1, 9, 1, 0);
      #1;
      n = 0;
      for (int i = 0; i < 8 && stall_b; i++) begin
         n++;
         tick();
      end
      tests++; if (n !== 2) begin failed++; $display("FAIL ls2_adj_stalls got=%0d exp=2", n); end
      tick();
      tests++; if (ex_valid_b !== 1'b1 || ex_rd_b !== 5'd9) begin failed++; $display("FAIL ls2_adj_issue got=%b/%0d exp=1/9", ex_valid_b, ex_rd_b); end
      tests++; if (stall_cycles_b !== sc + 3'd2) begin failed++; $display("FAIL ls2_adj_cnt got=%0d exp=%0d", stall_cycles_b, sc + 3'd2); end
      $display("[TB] LS2 load; use: stall cycles observed=%0d", n);
      idle();
   endtask

   task automatic test_flush;
      logic [15:0] sc;
      idle();
      tick(); tick(); tick();
      instr(2, 0, 1, 0, 3, 1, 1);
      tick();
      instr(3, 0, 1, 0, 5, 1, 0);
      ctrl = 16'h00FF;
      #1;
      tests++; if (stall_a !== 1'b1) begin failed++; $display("FAIL fl_pre_stall got=%b exp=1", stall_a); end
      flush = 1;
      #1;
      tests++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin failed++; $display("FAIL fl_stall got=%b/%b exp=0/0", stall_a, stall_b); end
      sc = stall_cycles_a;
      tick();
      tests++; if (ex_valid_a !== 1'b0 || ex_ctrl_a !== 16'h0) begin failed++; $display("FAIL fl_bubble got=%b/%h exp=0/0", ex_valid_a, ex_ctrl_a); end
      tests++; if (stall_cycles_a !== sc) begin failed++; $display("FAIL fl_cnt got=%0d exp=%0d", stall_cycles_a, sc); end
      // the older load in the LOAD_STALL=2 scoreboard must survive the flush
      flush = 0;
      #1;
      tests++; if (stall_b !== 1'b1 || stall_a !== 1'b0) begin failed++; $display("FAIL fl_older_live got=%b/%b exp=1/0", stall_b, stall_a); end
      tick();
      tests++; if (stall_b !== 1'b0) begin failed++; $display("FAIL fl_older_end got=%b exp=0", stall_b); end
      tick();
      $display("[TB] flush during hazard: ex_valid=%b cnt=%0d", ex_valid_a, stall_cycles_a);
      idle();
   endtask

   task automatic test_reset_mid_stall;
      idle();
      tick(); tick(); tick();
      instr(2, 0, 1, 0, 3, 1, 1);
      pc = 32'h40; imm = 32'h8;
      tick();
      instr(3, 0, 1, 0, 4, 1, 0);
      #1;
      tests++; if (stall_a !== 1'b1) begin failed++; $display("FAIL rst_pre_stall got=%b exp=1", stall_a); end
      #2;
      rst_n = 0;
      #1;
      tests++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin failed++; $display("FAIL rst_stall got=%b/%b exp=0/0", stall_a, stall_b); end
      tests++; if (ex_memread_a !== 1'b0 || ex_rd_a !== 5'd0 || ex_pc_a !== 32'h0 || ex_imm_a !== 32'h0)
         begin failed++; $display("FAIL rst_ex got mr=%b rd=%0d pc=%h imm=%h exp=0", ex_memread_a, ex_rd_a, ex_pc_a, ex_imm_a); end
      tests++; if (stall_cycles_a !== 16'h0 || stall_cycles_b !== 3'h0) begin failed++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cycles_a, stall_cycles_b); end
      $display("[TB] reset mid-stall: stall=%b ex_memread=%b cnt=%0d", stall_a, ex_memread_a, stall_cycles_a);
      idle();
      @(negedge clk);
      rst_n = 1;
      tick();
      instr(5, 0, 1, 0, 0, 0, 0);
      tick();
      tests++; if (ex_rs1_data_a !== 32'h0) begin failed++; $display("FAIL rst_rf_clear got=%h exp=0", ex_rs1_data_a); end
      idle();
   endtask

   task automatic test_saturate;
      idle();
      tick(); tick();
      for (int r = 0; r < 5; r++) begin
         instr(2, 0, 1, 0, 3, 1, 1);
         tick();
         instr(3, 0, 1, 0, 4, 1, 0);
         #1;
         for (int i = 0; i < 8 && stall_b; i++) begin
            tick();
         end
         tick();
         idle();
         if (r == 2) begin
            tests++; if (stall_cycles_b !== 3'd6) begin failed++; $display("FAIL sat_mid got=%0d exp=6", stall_cycles_b); end
         end
         $display("[TB] saturate round %0d: cnt_ls2=%0d cnt_ls1=%0d", r, stall_cycles_b, stall_cycles_a);
      end
      tests++; if (stall_cycles_b !== 3'd7) begin failed++; $display("FAIL sat_end got=%0d exp=7", stall_cycles_b); end
      tests++; if (stall_cycles_a !== 16'd5) begin failed++; $display("FAIL sat_ls1 got=%0d exp=5", stall_cycles_a); end
   endtask

   initial begin
      idle();
      rst_n = 0;
      test_reset();
      test_regfile();
      test_bypass();
      test_load_use_ls1();
      test_load_use_ls2();
      test_flush();
      test_reset_mid_stall();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/pipeline_id_hazard.md
# pipeline_id_hazard

Parametrised decode stage for the 5-stage RISC-V pipeline. It holds the register file with write-through bypass, a depth-configurable load-use scoreboard that generates IF stalls and EX bubbles, and the ID/EX pipeline register with flush support. It sits between the IF/ID register and the EX stage. Control decode and immediate generation stay external and arrive here already decoded.

## Interface
Parameters:
- XLEN, 32, datapath width
- AW, 5, register address width (2**AW registers; x0 hardwired zero)
- CTRL_W, 16, width of opaque decoded-control bundle passed to EX
- LOAD_STALL, 1, cycles a load result is unavailable after leaving ID (1..4)
- CNT_W, 16, stall performance counter width

Ports:
- clk_ID  in  1  clock, rising edge
- rst_n_ID  in  1  asynchronous active-low reset
- valid_ID  in  1  IF/ID holds a real instruction
- rs1_addr_ID, rs2_addr_ID  in  AW  source register addresses
- rs1_used_ID, rs2_used_ID  in  1  instruction actually reads rs1/rs2
- rd_addr_ID  in  AW  destination register
- regwrite_ID  in  1  instruction writes rd
- memread_ID  in  1  instruction is a load
- ctrl_ID  in  CTRL_W  decoded control bundle
- imm_ID, pc_ID  in  XLEN  immediate, PC
- wb_we  in  1  WB write enable
- wb_addr  in  AW  WB destination
- wb_data  in  XLEN  WB data
- flush_EX  in  1  taken branch/jump in EX; squash ID
- stall_IF  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  XLEN  registered operands
- ex_rs1_addr, ex_rs2_addr, ex_rd  out  AW  registered addresses (for forwarding unit)
- ex_regwrite, ex_memread  out  1  registered
- ex_ctrl  out  CTRL_W  registered control
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- Register file:
  - 2**AW x XLEN, written on the rising edge when wb_we && wb_addr!=0.
  - Reads are combinational.
  - Write-through: if wb_we && wb_addr==rsN_addr_ID && wb_addr!=0, read returns wb_data in the same cycle.
  - Register 0 always reads 0.
- Scoreboard: LOAD_STALL-entry shift register of {pv, prd}.
  - Each edge, entry k moves to k+1 and the last entry drops.
  - Entry 0 loads {1, rd_addr_ID} when an instruction issues with memread_ID && regwrite_ID && rd_addr_ID!=0. Otherwise entry 0 loads {0, x}.
- Hazard: hz = valid_ID && not flush_EX && there exists k with pv[k] && ((rs1_used_ID && prd[k]==rs1_addr_ID) || (rs2_used_ID && prd[k]==rs2_addr_ID)). Address 0 never matches because it is never recorded.
- stall_IF = hz.
- Issue = valid_ID && not hz && not flush_EX.
- ID/EX update each edge:
  - If issue: capture all ex_* from the ID inputs and register reads, with ex_valid=1.
  - Otherwise insert a bubble: ex_valid=0, ex_ctrl=0, ex_regwrite=0, ex_memread=0. Data fields may hold any value.
- Priority: flush_EX over hz. On flush, stall_IF=0 and a bubble is inserted. Scoreboard entries 1..N still shift, because older loads remain live.
- stall_cycles increments on every edge where stall_IF=1 and saturates at all-ones.

## Timing
- Reset (asynchronous, while rst_n_ID=0):
  - All registers, ex_* and stall_cycles are 0.
  - All pv are 0, so stall_IF=0.
  - Reset asserted mid-stall clears the scoreboard immediately.
- stall_IF is combinational from the current ID inputs and scoreboard state. It is asserted in the same cycle the hazardous instruction sits in ID.
- ID to EX latency is 1 cycle.
- A dependent instruction immediately after a load stalls for exactly LOAD_STALL cycles. An instruction with one unrelated instruction between it and the load stalls for LOAD_STALL-1 cycles (minimum 0).
- A WB write and a dependent read in the same cycle resolve by bypass, with no stall.
- A simultaneous rs1 and rs2 match stalls once, not twice.

## Test plan
- Reset, then write x5=0xDEADBEEF via WB, then read rs1=5 → ex_rs1_data=0xDEADBEEF one cycle later. A write to x0 followed by a read of x0 → 0.
- Bypass: wb_we=1, wb_addr=7, wb_data=0x1234 in the same cycle as rs2_addr_ID=7, rs2_used=1 → ex_rs2_data=0x1234 and stall_IF=0.
- LOAD_STALL=1: load x3, then add x4,x3,x3 → stall_IF high for exactly 1 cycle and one bubble (ex_valid=0) before the add. stall_cycles=1.
- LOAD_STALL=2: load x3; unrelated instruction; use of x3 → 1 stall cycle. With the use immediately after the load → 2 stall cycles.
- flush_EX=1 during a hazard → stall_IF=0, ex_valid=0 next cycle, stall_cycles unchanged.
- rst_n_ID pulled low during a stall → stall_IF=0 and all ex_* equal 0 immediately, without waiting for a clock edge.
